// File: rtl/vga_timing_drv.sv
// 800x600@72 raster timing with a two-stage coordinate/colour pipeline.
// Optional VGA_TEST_PATTERN_EN replaces vga_data with eight colour bars.
module vga_timing_drv #(
  parameter int H_SYNC   = 120,
  parameter int H_BACK   = 64,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 56,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 23,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 37,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_data,
  output logic [9:0] vga_xide,
  output logic [9:0] vga_yide,
  output logic       vga_de,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [7:0] vga_rgb,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SE   = 11'(H_SYNC);
  localparam logic [10:0] H_AS   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_AE   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_SE   = 11'(V_SYNC);
  localparam logic [10:0] V_AS   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_AE   = 11'(V_SYNC + V_BACK + V_ACTIVE);

  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;

  logic        hs0, vs0, de0, tick0;
  logic [10:0] xsub, ysub;

  logic [9:0]  x1_q, x1_d;
  logic [9:0]  y1_q, y1_d;
  logic        de1_q, hs1_q, vs1_q, tick1_q;

  logic [7:0]  pix_src;
  logic [7:0]  rgb_q, rgb_d;
  logic        de2_q, hs2_q, vs2_q, tick2_q;
  logic        hs2_d, vs2_d;

  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
    end
  end

  always_comb begin
    hs0   = (h_q < H_SE);
    vs0   = (v_q < V_SE);
    de0   = (h_q >= H_AS) && (h_q < H_AE) &&
            (v_q >= V_AS) && (v_q < V_AE);
    tick0 = (h_q == '0) && (v_q == '0);
    xsub  = h_q - H_AS;
    ysub  = v_q - V_AS;
    x1_d  = de0 ? xsub[9:0] : '0;
    y1_d  = de0 ? ysub[9:0] : '0;
  end

`ifdef VGA_TEST_PATTERN_EN
  // Bars are 100 px wide: FF FC 1F 1C E3 E0 03 00.
  function automatic logic [7:0] bar_rgb(input logic [9:0] x);
    logic [7:0] c;
    c = 8'h00;
    if (x < 10'd100)      c = 8'hFF;
    else if (x < 10'd200) c = 8'hFC;
    else if (x < 10'd300) c = 8'h1F;
    else if (x < 10'd400) c = 8'h1C;
    else if (x < 10'd500) c = 8'hE3;
    else if (x < 10'd600) c = 8'hE0;
    else if (x < 10'd700) c = 8'h03;
    return c;
  endfunction

  assign pix_src = bar_rgb(x1_q);
`else
  assign pix_src = vga_data;
`endif

  always_comb begin
    rgb_d = de1_q ? pix_src : 8'h00;
    hs2_d = hs1_q ? SYNC_POL : ~SYNC_POL;
    vs2_d = vs1_q ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      tick1_q <= 1'b0;
      rgb_q   <= '0;
      de2_q   <= 1'b0;
      hs2_q   <= ~SYNC_POL;
      vs2_q   <= ~SYNC_POL;
      tick2_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      de1_q   <= de0;
      hs1_q   <= hs0;
      vs1_q   <= vs0;
      tick1_q <= tick0;
      rgb_q   <= rgb_d;
      de2_q   <= de1_q;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      tick2_q <= tick1_q;
    end
  end

  assign vga_xide   = x1_q;
  assign vga_yide   = y1_q;
  assign vga_de     = de2_q;
  assign vga_hs     = hs2_q;
  assign vga_vs     = vs2_q;
  assign vga_rgb    = rgb_q;
  assign frame_tick = tick2_q;

endmodule

// File: tb/tb_vga_timing_drv.sv
// Directed bench for vga_timing_drv: reset, line/frame-start timing,
// pixel pipeline alignment, blanking and mid-line reset.
module tb_vga_timing_drv;

  logic       clk;
  logic       rst_n;
  logic [7:0] vga_data;
  logic [9:0] vga_xide;
  logic [9:0] vga_yide;
  logic       vga_de;
  logic       vga_hs;
  logic       vga_vs;
  logic [7:0] vga_rgb;
  logic       frame_tick;

  bit ff_mode;
  int n_cmp;
  int n_err;

  assign vga_data = ff_mode ? 8'hFF : vga_xide[7:0];

  vga_timing_drv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_data   (vga_data),
    .vga_xide   (vga_xide),
    .vga_yide   (vga_yide),
    .vga_de     (vga_de),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_rgb    (vga_rgb),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic int exp_pix(input int x);
`ifdef VGA_TEST_PATTERN_EN
    int bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C,
                     8'hE3, 8'hE0, 8'h03, 8'h00};
    return bars[x / 100];
`else
    return x & 8'hFF;
`endif
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_xide"}, vga_xide, 0);
    chk({tag, "_yide"}, vga_yide, 0);
    chk({tag, "_de"},   vga_de, 0);
    chk({tag, "_rgb"},  vga_rgb, 0);
    chk({tag, "_tick"}, frame_tick, 0);
    chk({tag, "_hs"},   vga_hs, 0);
    chk({tag, "_vs"},   vga_vs, 0);
  endtask

  task automatic release_and_check(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_hs_c1"},   vga_hs, 0);
    chk({tag, "_tick_c1"}, frame_tick, 0);
    @(posedge clk); #1;
    chk({tag, "_hs_c2"},   vga_hs, 1);
    chk({tag, "_vs_c2"},   vga_vs, 1);
    chk({tag, "_tick_c2"}, frame_tick, 1);
    @(posedge clk); #1;
    chk({tag, "_tick_c3"}, frame_tick, 0);
  endtask

  int hs_l0, hs_rise2, n_hs_rise, last_hs_rise;
  int vs_cnt, vs_fall, tick_cnt;
  int de_rise, de_off, de_rises, first_len, run_x;
  int run_err, blank_err, ymax;
  int x_at_rise, y_at_rise, rgb_150, rgb_799;
  int waited;
  logic prev_hs, prev_vs, prev_de;

  initial begin
    n_cmp = 0;
    n_err = 0;
    ff_mode = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_reset_outs("rst");

    hs_l0 = 0; hs_rise2 = -1; n_hs_rise = 0; last_hs_rise = 0;
    vs_cnt = 0; vs_fall = -1; tick_cnt = 0;
    de_rise = -1; de_off = -1; de_rises = 0; first_len = 0;
    run_x = 0; run_err = 0; blank_err = 0; ymax = 0;
    x_at_rise = -1; y_at_rise = -1; rgb_150 = -1; rgb_799 = -1;
    prev_hs = 1'b0; prev_vs = 1'b0; prev_de = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 32300; n++) begin
      @(posedge clk); #1;
      if (!vga_de && vga_rgb != 8'h00) blank_err++;
      if (vga_hs && !prev_hs) begin
        n_hs_rise++;
        if (n_hs_rise == 2) hs_rise2 = n;
        last_hs_rise = n;
      end
      if (n >= 2 && n <= 1041 && vga_hs) hs_l0++;
      if (vga_vs) vs_cnt++;
      if (!vga_vs && prev_vs && vs_fall < 0) vs_fall = n;
      if (frame_tick) tick_cnt++;
      if (vga_de && !prev_de) begin
        de_rises++;
        run_x = 0;
        if (de_rise < 0) begin
          de_rise = n;
          de_off = n - last_hs_rise;
          x_at_rise = vga_xide;
          y_at_rise = vga_yide;
        end
      end
      if (!vga_de && prev_de && first_len == 0) first_len = run_x;
      if (vga_de) begin
        if (vga_rgb != exp_pix(run_x)) run_err++;
        if (run_x == 150 && rgb_150 < 0) rgb_150 = vga_rgb;
        if (run_x == 799 && rgb_799 < 0) rgb_799 = vga_rgb;
        run_x++;
      end
      if (vga_yide > ymax) ymax = vga_yide;
      prev_hs = vga_hs;
      prev_vs = vga_vs;
      prev_de = vga_de;
      if (n == 30000) ff_mode = 1'b0;
    end

    chk("hs_width", hs_l0, 120);
    chk("hs_period", hs_rise2, 1042);
    chk("vs_width", vs_cnt, 6240);
    chk("vs_fall", vs_fall, 6242);
    chk("tick_cnt", tick_cnt, 1);
    chk("de_first", de_rise, 2 + 29 * 1040 + 184);
    chk("de_off_hs", de_off, 184);
    chk("de_len", first_len, 800);
    chk("de_runs", de_rises, 2);
    chk("x_at_rise", x_at_rise, 1);
    chk("y_at_rise", y_at_rise, 0);
    chk("ymax", ymax, 1);
    chk("pix_err", run_err, 0);
    chk("blank_err", blank_err, 0);
`ifdef VGA_TEST_PATTERN_EN
    chk("rgb_x150", rgb_150, 8'hFC);
    chk("rgb_x799", rgb_799, 8'h00);
`else
    chk("rgb_x150", rgb_150, 8'h96);
    chk("rgb_x799", rgb_799, 8'h1F);
`endif

    waited = 0;
    while (!vga_de && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("de_wait", vga_de, 1);
    repeat (37) @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("hold");
    release_and_check("rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
